// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline (A) vs multi-cycle unit (B), with a
// busy scoreboard and hazard stall. Optional forwarding macro: REGFILE_WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            sb_set_valid,
  input  logic [4:0]      sb_set_addr,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic            dec_use_rd,
  output logic            hazard,
  output logic            reg_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 8;

  typedef enum logic {NORMAL, FORCE_B} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            grant_a;
  logic            grant_b;
  logic            b_denied;

  // Grant selection; nothing is accepted while reset is asserted
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (state == NORMAL) begin
        a_ready = a_valid;
        b_ready = b_valid & ~a_valid;
      end else begin
        b_ready = b_valid;
      end
    end
  end

  assign grant_a  = a_valid & a_ready;
  assign grant_b  = b_valid & b_ready;
  assign b_denied = b_valid & ~b_ready;

  // Write port follows the grant with no added latency; x0 is never written
  always_comb begin
    reg_wen = 1'b0;
    rd_addr = '0;
    rd_data = '0;
    if (grant_a) begin
      reg_wen = (a_addr != 5'd0);
      rd_addr = a_addr;
      rd_data = a_data;
    end else if (grant_b) begin
      reg_wen = (b_addr != 5'd0);
      rd_addr = b_addr;
      rd_data = b_data;
    end
  end

  // Issue sets after the retire clear so a same-edge collision leaves the entry busy
  always_comb begin
    busy_nxt = busy;
    if (grant_b)      busy_nxt[b_addr]      = 1'b0;
    if (sb_set_valid) busy_nxt[sb_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      if (b_denied) begin
        if (starve_cnt < CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
      case (state)
        NORMAL:  if (b_denied && (starve_cnt == CW'(STARVE_LIMIT - 1))) state <= FORCE_B;
        FORCE_B: if (grant_b || !b_valid) state <= NORMAL;
        default: state <= NORMAL;
      endcase
      busy <= busy_nxt;
    end
  end

  assign hazard = ~rst & ((dec_use_rs1 & busy[dec_rs1]) |
                          (dec_use_rs2 & busy[dec_rs2]) |
                          (dec_use_rd  & busy[dec_rd]));

`ifdef REGFILE_WB_ARB_BYPASS_EN
  // Forward the same-cycle write around the register file's asynchronous read
  assign rs1_data = (reg_wen && (rd_addr == dec_rs1) && (dec_rs1 != 5'd0)) ? rd_data : rf_rs1_data;
  assign rs2_data = (reg_wen && (rd_addr == dec_rs2) && (dec_rs2 != 5'd0)) ? rd_data : rf_rs2_data;
`else
  assign rs1_data = rf_rs1_data;
  assign rs2_data = rf_rs2_data;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the in-order pipeline (port A) and a multi-cycle execution unit such as mul/div (port B).
- Keeps a 32-entry scoreboard of destinations with multi-cycle ops in flight, and raises a hazard stall to decode.
- Prevents starvation of port B with a bounded-wait counter.
- Drives the register file write port (reg_wen, rd_addr, rd_data) directly, with no added latency.

Parameters:
- XLEN, 32, data width of write and read data.
- STARVE_LIMIT, 4, consecutive cycles B may be denied before A is back-pressured; legal range 1..255.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  pipeline writeback request
- a_addr  input  5  pipeline destination register
- a_data  input  XLEN  pipeline writeback data
- a_ready  output  1  A accepted this cycle; pipeline stalls when low
- b_valid  input  1  multi-cycle unit result valid
- b_addr  input  5  multi-cycle destination register
- b_data  input  XLEN  multi-cycle result
- b_ready  output  1  B accepted this cycle
- sb_set_valid  input  1  multi-cycle op issued this cycle
- sb_set_addr  input  5  its destination register
- dec_rs1, dec_rs2, dec_rd  input  5 each  decoding instruction's register fields
- dec_use_rs1, dec_use_rs2, dec_use_rd  input  1 each  field is meaningful
- hazard  output  1  decode must stall
- reg_wen  output  1  register file write enable
- rd_addr  output  5  register file write address
- rd_data  output  XLEN  register file write data
- rf_rs1_data, rf_rs2_data  input  XLEN  register file read data for dec_rs1/dec_rs2
- rs1_data, rs2_data  output  XLEN  operand data to execute

Behaviour:
- FSM states: NORMAL and FORCE_B. Reset state is NORMAL, starve_cnt=0, busy=0.
- NORMAL:
  - a_valid wins: a_ready=1.
  - b_ready = b_valid & ~a_valid.
  - A request with a_addr==0 still counts as granted, but produces no write.
- FORCE_B:
  - a_ready=0.
  - b_ready=b_valid.
- Write port (combinational from the grant):
  - reg_wen = (a_valid&a_ready&(a_addr!=0)) | (b_valid&b_ready&(b_addr!=0)).
  - rd_addr/rd_data mux to the granted source.
  - With no grant, rd_addr=0 and rd_data=0.
- starve_cnt:
  - Increments when b_valid & ~b_ready.
  - Clears to 0 on any B grant or when b_valid=0.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - NORMAL->FORCE_B when b_valid & ~b_ready and starve_cnt==STARVE_LIMIT-1.
  - FORCE_B->NORMAL on a B grant, or if b_valid drops.
- Scoreboard busy[31:1] (busy[0] hardwired 0):
  - Set on sb_set_valid at the edge.
  - Cleared on a B grant for b_addr at the edge.
  - Simultaneous set and clear of the same address: set wins.
  - Set of an already-busy address: stays busy; issue logic is expected to prevent this through hazard.
- hazard = (dec_use_rs1&busy[dec_rs1]) | (dec_use_rs2&busy[dec_rs2]) | (dec_use_rd&busy[dec_rd]).
  - Purely combinational from the current busy bits; a same-cycle clear is not visible until the next cycle.
- Reset mid-operation:
  - Clears busy, starve_cnt and FSM.
  - During the rst cycle, reg_wen=0, a_ready=0 and b_ready=0.
- Outputs at reset: a_ready=0, b_ready=0, reg_wen=0, rd_addr=0, rd_data=0, hazard=0.
- rs1_data/rs2_data: pass-through of rf_rs1_data/rf_rs2_data unless the optional feature below is compiled in.

Optional Feature:
- Macro: REGFILE_WB_ARB_BYPASS_EN.
- With the macro:
  - rs1_data = rd_data when reg_wen & (rd_addr==dec_rs1) & (dec_rs1!=0); otherwise rf_rs1_data. rs2_data follows the same rule.
  - This forwards the same-cycle write past the register file's asynchronous read.
- Without the macro: rs1_data=rf_rs1_data and rs2_data=rf_rs2_data, unconditionally.

Test Plan:
- Reset, then idle -> all outputs 0, busy all 0, hazard=0.
- a_valid=1, a_addr=5, a_data=0xDEADBEEF, b_valid=0 -> same cycle: a_ready=1, reg_wen=1, rd_addr=5, rd_data=0xDEADBEEF.
- a_valid=1 continuously, b_valid=1, b_addr=7 (STARVE_LIMIT=4):
  - b_ready=0 for cycles 0-3.
  - Cycle 4: a_ready=0, b_ready=1, rd_addr=7.
  - Cycle 5: back to A.
- sb_set_valid with addr 9; then dec_rs2=9, dec_use_rs2=1 -> hazard=1 until the cycle after the B grant to x9, then 0.
- Same-edge sb_set and B clear on addr 12 -> busy[12]=1 afterwards. Separately, a_addr=0 with a_valid=1 -> a_ready=1, reg_wen=0.
- With REGFILE_WB_ARB_BYPASS_EN: A writes x3=0x1234 while dec_rs1=3 and rf_rs1_data=0 -> rs1_data=0x1234. Without the macro -> rs1_data=0.
